// File: rtl/ps2_gpio_rx.sv
// PS/2 device-to-host frame receiver for one forwarded GPIO channel.
// Synchronizes and glitch-filters the PS/2 clock, deframes 11-bit frames,
// checks start/stop framing and odd parity, and emits one-cycle strobes.
module ps2_gpio_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       busy
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Input conditioning and clock filter state
    logic          clk_meta_q, clk_meta_d;
    logic          clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d;
    logic          dat_sync_q, dat_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic          filt_dly_q, filt_dly_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d;

    // Deframer state
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;

    // Registered outputs
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_parity_err_q, rx_parity_err_d;
    logic          rx_frame_err_q, rx_frame_err_d;
    logic          rx_timeout_q, rx_timeout_d;
    logic          busy_q, busy_d;

    // Synchronize both lines, filter the clock, and register its falling edge
    always_comb begin
        clk_meta_d = ps2_clk_in;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2_dat_in;
        dat_sync_d = dat_meta_q;
        filt_clk_d = filt_clk_q;
        run_cnt_d  = '0;
        filt_dly_d = filt_clk_q;
        fall_d     = filt_dly_q & ~filt_clk_q;
        if (clk_sync_q != filt_clk_q) begin
            if (run_cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                run_cnt_d = run_cnt_q + CW'(1);
            end
        end
    end

    // Frame state machine: next state, timeout, and strobe generation
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        parity_d        = parity_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        rx_parity_err_d = 1'b0;
        rx_frame_err_d  = 1'b0;
        rx_timeout_d    = 1'b0;
        timer_d         = (fall_q || state_q == IDLE) ? '0 : timer_q + TW'(1);

        if (state_q != IDLE && !fall_q && timer_d == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon a stalled partial frame
            rx_timeout_d = 1'b1;
            state_d      = IDLE;
            bit_cnt_d    = '0;
            shift_d      = '0;
        end else if (fall_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        rx_frame_err_d = 1'b1;
                    end
                end
                SHIFT: begin
                    shift_d = {dat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = dat_sync_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_sync_q) begin
                        rx_frame_err_d = 1'b1;
                    end else if (^{shift_q, parity_q}) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_parity_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // All state registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q      <= 1'b1;
            clk_sync_q      <= 1'b1;
            dat_meta_q      <= 1'b1;
            dat_sync_q      <= 1'b1;
            filt_clk_q      <= 1'b1;
            filt_dly_q      <= 1'b1;
            fall_q          <= 1'b0;
            run_cnt_q       <= '0;
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            parity_q        <= 1'b0;
            timer_q         <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_timeout_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            clk_meta_q      <= clk_meta_d;
            clk_sync_q      <= clk_sync_d;
            dat_meta_q      <= dat_meta_d;
            dat_sync_q      <= dat_sync_d;
            filt_clk_q      <= filt_clk_d;
            filt_dly_q      <= filt_dly_d;
            fall_q          <= fall_d;
            run_cnt_q       <= run_cnt_d;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            timer_q         <= timer_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
            rx_timeout_q    <= rx_timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_timeout    = rx_timeout_q;
    assign busy          = busy_q;

endmodule
